// File: rtl/apb_master_ctrl.sv
// APB4 requester: turns single valid/ready commands into SETUP/ACCESS transfers
// toward two address-decoded slaves and returns data/error on a response port.
module apb_master_ctrl #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE0 = 'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE0   = 'h0000_1FFF,
    parameter logic [ADDR_WIDTH-1:0] A_START_SLAVE1 = 'h0000_2000,
    parameter logic [ADDR_WIDTH-1:0] A_END_SLAVE1   = 'h0000_2FFF,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [3:0]            cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL_S0,
    output logic                  PSEL_S1,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_WIDTH-1:0] PRDATA_S0,
    input  logic [DATA_WIDTH-1:0] PRDATA_S1,
    input  logic                  PREADY_S0,
    input  logic                  PREADY_S1,
    input  logic                  PSLVERR_S0,
    input  logic                  PSLVERR_S1
);

    // A zero TIMEOUT_CYCLES would give a zero-width counter, so keep one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        to_cnt;
    logic                    hit_s0;
    logic                    hit_s1;
    logic                    sel_ready;
    logic                    sel_slverr;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    timeout_hit;

    always_comb begin
        hit_s0      = (cmd_addr >= A_START_SLAVE0) && (cmd_addr <= A_END_SLAVE0);
        hit_s1      = (cmd_addr >= A_START_SLAVE1) && (cmd_addr <= A_END_SLAVE1);
        sel_ready   = PSEL_S1 ? PREADY_S1  : PREADY_S0;
        sel_slverr  = PSEL_S1 ? PSLVERR_S1 : PSLVERR_S0;
        sel_rdata   = PSEL_S1 ? PRDATA_S1  : PRDATA_S0;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL_S0   <= 1'b0;
            PSEL_S1   <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        PADDR     <= cmd_addr;
                        PWDATA    <= cmd_wdata;
                        PWRITE    <= cmd_write;
                        PSTRB     <= cmd_write ? cmd_strb : 4'b0000;
                        PPROT     <= cmd_prot;
                        to_cnt    <= '0;
                        if (hit_s0 || hit_s1) begin
                            PSEL_S0 <= hit_s0;
                            PSEL_S1 <= hit_s1 && !hit_s0;
                            state   <= SETUP;
                        end else begin
                            // Unmapped address: answer at once without touching the bus.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (sel_ready) begin
                        PSEL_S0   <= 1'b0;
                        PSEL_S1   <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= sel_slverr;
                        rsp_rdata <= PWRITE ? '0 : sel_rdata;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        PSEL_S0   <= 1'b0;
                        PSEL_S1   <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
